// File: rtl/sargantana_icache_way_ctrl_if.sv
// sargantana_icache_way_ctrl_if: lookup/refill handshakes, way memory port and flush status
interface sargantana_icache_way_ctrl_if #(
  parameter int SET_WIDHT  = 256,
  parameter int ADDR_WIDHT = 7
);
  logic                  flush;
  logic                  lkp_valid;
  logic [ADDR_WIDHT-1:0] lkp_addr;
  logic                  lkp_ready;
  logic                  rfl_valid;
  logic [ADDR_WIDHT-1:0] rfl_addr;
  logic [SET_WIDHT-1:0]  rfl_data;
  logic                  rfl_ready;
  logic                  way_req;
  logic                  way_we;
  logic [ADDR_WIDHT-1:0] way_addr;
  logic [SET_WIDHT-1:0]  way_wdata;
  logic [SET_WIDHT-1:0]  way_rdata;
  logic                  rd_valid;
  logic [SET_WIDHT-1:0]  rd_data;
  logic                  busy;
  logic                  flush_done;
  modport slave (
    input  flush, lkp_valid, lkp_addr, rfl_valid, rfl_addr, rfl_data, way_rdata,
    output lkp_ready, rfl_ready, way_req, way_we, way_addr, way_wdata, rd_valid, rd_data, busy, flush_done
  );
  modport master (
    output flush, lkp_valid, lkp_addr, rfl_valid, rfl_addr, rfl_data, way_rdata,
    input  lkp_ready, rfl_ready, way_req, way_we, way_addr, way_wdata, rd_valid, rd_data, busy, flush_done
  );
endinterface

// File: rtl/sargantana_icache_way_ctrl.sv
// sargantana_icache_way_ctrl: arbitrates lookups/refills onto one way port and sweeps it clean on flush
module sargantana_icache_way_ctrl #(
  parameter int SET_WIDHT  = 256,
  parameter int ADDR_WIDHT = 7,
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  sargantana_icache_way_ctrl_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [ADDR_WIDHT-1:0] LAST = '1;
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDHT-1:0] cnt;
  logic [SW-1:0] starve;
  logic rd_v, idle, sweep, rfl_gnt, lkp_gnt;
  assign idle    = state == IDLE;
  assign sweep   = !idle || bus.flush;
  assign rfl_gnt = idle && !bus.flush && bus.rfl_valid && !(starve == SMAX && bus.lkp_valid);
  assign lkp_gnt = idle && !bus.flush && bus.lkp_valid && !rfl_gnt;
  // state register
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_nxt;
  // next state: enter sweep on flush, leave after the last set is written
  always_comb
    state_nxt = idle ? (bus.flush ? FLUSH : IDLE) : (cnt == LAST ? IDLE : FLUSH);
  // way port, handshakes and status; everything forced low while in reset
  always_comb begin
    bus.way_req    = !rst_i && (sweep || rfl_gnt || lkp_gnt);
    bus.way_we     = !rst_i && (sweep || rfl_gnt);
    bus.way_addr   = rst_i ? '0 : sweep ? cnt : rfl_gnt ? bus.rfl_addr : lkp_gnt ? bus.lkp_addr : '0;
    bus.way_wdata  = (!rst_i && !sweep && rfl_gnt) ? bus.rfl_data : '0;
    bus.rfl_ready  = !rst_i && rfl_gnt;
    bus.lkp_ready  = !rst_i && lkp_gnt;
    bus.rd_valid   = !rst_i && rd_v;
    bus.rd_data    = (!rst_i && rd_v) ? bus.way_rdata : '0;
    bus.busy       = !rst_i && sweep;
    bus.flush_done = !rst_i && sweep && cnt == LAST;
  end
  // sweep address counter, wraps back to 0 after the last set
  always_ff @(posedge clk_i)
    cnt <= rst_i ? '0 : sweep ? cnt + 1'b1 : cnt;
  // starvation counter: refills that bypassed a waiting lookup, cleared when a lookup wins
  always_ff @(posedge clk_i)
    if (rst_i || lkp_gnt) starve <= '0;
    else if (rfl_gnt && bus.lkp_valid && starve != SMAX) starve <= starve + 1'b1;
  // read data is valid the cycle after a lookup grant
  always_ff @(posedge clk_i)
    rd_v <= !rst_i && lkp_gnt;
endmodule

// File: tb/tb_sargantana_icache_way_ctrl.sv
// tb_sargantana_icache_way_ctrl: directed checks of arbitration, starvation, flush sweep and reset
module tb_sargantana_icache_way_ctrl;
  logic clk = 0, rst = 1;
  int passed = 0, total = 0, dones;
  sargantana_icache_way_ctrl_if #(.SET_WIDHT(256), .ADDR_WIDHT(7)) bus ();
  sargantana_icache_way_ctrl #(.SET_WIDHT(256), .ADDR_WIDHT(7), .STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  localparam logic [255:0] PA5 = {32{8'hA5}};
  localparam logic [255:0] PRF = {8{32'hDEADBEEF}};
  localparam logic [255:0] P3C = {32{8'h3C}};
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  initial begin
    bus.flush = 0; bus.lkp_valid = 1; bus.lkp_addr = 7'h05;
    bus.rfl_valid = 1; bus.rfl_addr = 7'h11; bus.rfl_data = PRF; bus.way_rdata = PA5;
    tick; tick; settle;
    chk("rst_way_req", 256'(bus.way_req), 0);
    chk("rst_lkp_ready", 256'(bus.lkp_ready), 0);
    chk("rst_rfl_ready", 256'(bus.rfl_ready), 0);
    chk("rst_busy", 256'(bus.busy), 0);
    chk("rst_rd_valid", 256'(bus.rd_valid), 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_way_wdata", bus.way_wdata, 0);
    tick; rst = 0; bus.rfl_valid = 0; settle;
    chk("lkp_req", 256'(bus.way_req), 1);
    chk("lkp_we", 256'(bus.way_we), 0);
    chk("lkp_addr", 256'(bus.way_addr), 5);
    chk("lkp_ready", 256'(bus.lkp_ready), 1);
    chk("lkp_rfl_ready", 256'(bus.rfl_ready), 0);
    tick; bus.lkp_valid = 0; settle;
    chk("lkp_rd_valid", 256'(bus.rd_valid), 1);
    chk("lkp_rd_data", bus.rd_data, PA5);
    chk("idle_req", 256'(bus.way_req), 0);
    chk("idle_we", 256'(bus.way_we), 0);
    tick; bus.rfl_valid = 1; bus.rfl_addr = 7'h33; settle;
    chk("rd_valid_once", 256'(bus.rd_valid), 0);
    chk("rfl_we", 256'(bus.way_we), 1);
    chk("rfl_addr", 256'(bus.way_addr), 7'h33);
    chk("rfl_data", bus.way_wdata, PRF);
    chk("rfl_ready", 256'(bus.rfl_ready), 1);
    chk("rfl_lkp_ready", 256'(bus.lkp_ready), 0);
    for (int i = 0; i < 6; i++) begin
      tick; bus.lkp_valid = 1; bus.lkp_addr = 7'h22; settle;
      chk($sformatf("starve_rfl_%0d", i), 256'(bus.rfl_ready), 256'(i != 4));
      chk($sformatf("starve_lkp_%0d", i), 256'(bus.lkp_ready), 256'(i == 4));
      chk($sformatf("starve_addr_%0d", i), 256'(bus.way_addr), i == 4 ? 256'h22 : 256'h33);
    end
    tick; bus.rfl_valid = 0; bus.lkp_addr = 7'h09; settle;
    chk("pre_flush_lkp_ready", 256'(bus.lkp_ready), 1);
    tick; bus.flush = 1; bus.rfl_valid = 1; bus.way_rdata = P3C; settle;
    chk("f0_rd_valid", 256'(bus.rd_valid), 1);
    chk("f0_rd_data", bus.rd_data, P3C);
    chk("f0_req", 256'(bus.way_req), 1);
    chk("f0_we", 256'(bus.way_we), 1);
    chk("f0_addr", 256'(bus.way_addr), 0);
    chk("f0_data", bus.way_wdata, 0);
    chk("f0_busy", 256'(bus.busy), 1);
    chk("f0_readies", 256'({bus.lkp_ready, bus.rfl_ready}), 0);
    chk("f0_done", 256'(bus.flush_done), 0);
    dones = 0;
    for (int i = 1; i < 128; i++) begin
      tick; bus.flush = (i == 50); settle;
      chk($sformatf("sw_addr_%0d", i), 256'(bus.way_addr), 256'(i));
      chk($sformatf("sw_ctl_%0d", i), 256'({bus.way_req, bus.way_we, bus.busy, bus.lkp_ready, bus.rfl_ready}), 256'(5'b11100));
      chk($sformatf("sw_data_%0d", i), bus.way_wdata, 0);
      chk($sformatf("sw_done_%0d", i), 256'(bus.flush_done), 256'(i == 127));
      dones += int'(bus.flush_done);
    end
    chk("sw_done_count", 256'(dones), 1);
    tick; bus.lkp_valid = 0; bus.rfl_valid = 0; settle;
    chk("post_busy", 256'(bus.busy), 0);
    chk("post_req", 256'(bus.way_req), 0);
    chk("post_done", 256'(bus.flush_done), 0);
    tick; bus.flush = 1; settle;
    chk("f2_addr0", 256'(bus.way_addr), 0);
    for (int i = 1; i < 60; i++) begin
      tick; bus.flush = 0; settle;
    end
    chk("f2_addr59", 256'(bus.way_addr), 59);
    tick; rst = 1; settle;
    chk("f2_rst_req", 256'(bus.way_req), 0);
    chk("f2_rst_busy", 256'(bus.busy), 0);
    tick; rst = 0; settle;
    chk("f2_after_busy", 256'(bus.busy), 0);
    chk("f2_after_req", 256'(bus.way_req), 0);
    chk("f2_after_done", 256'(bus.flush_done), 0);
    tick; bus.flush = 1; settle;
    chk("f3_addr0", 256'(bus.way_addr), 0);
    chk("f3_busy", 256'(bus.busy), 1);
    tick; bus.flush = 0; settle;
    chk("f3_addr1", 256'(bus.way_addr), 1);
    tick; rst = 1; tick; rst = 0; bus.lkp_valid = 1; bus.lkp_addr = 7'h7F; settle;
    chk("r39_lkp_ready", 256'(bus.lkp_ready), 1);
    tick; rst = 1; bus.lkp_valid = 0; settle;
    chk("r39_rd_valid_rst", 256'(bus.rd_valid), 0);
    tick; rst = 0; settle;
    chk("r39_rd_valid_after", 256'(bus.rd_valid), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
